// File: rtl/sreg_dreg_select_controller_pkg.sv
// ---------------------------------------------------------------
// sreg_dreg_select_controller_pkg : shared opcodes, states, classes
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

package sreg_dreg_select_controller_pkg;

  localparam logic [3:0] OP_TO   = 4'h1;
  localparam logic [3:0] OP_WITH = 4'h2;
  localparam logic [3:0] OP_FROM = 4'hB;

  localparam logic [3:0] DEFAULT_REG = 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_BUSY  = 2'd2,
    ST_MOVE  = 2'd3
  } state_t;

  // Bit positions of the one-hot opcode class vector
  localparam int CLS_WITH  = 0;
  localparam int CLS_TO    = 1;
  localparam int CLS_FROM  = 2;
  localparam int CLS_MOVE  = 3;
  localparam int CLS_MOVES = 4;
  localparam int CLS_OTHER = 5;
  localparam int CLS_W     = 6;

endpackage

`default_nettype wire

// File: rtl/sreg_dreg_select_controller_prefix_decode.sv
// ---------------------------------------------------------------
// gsu_prefix_decode : opcode + B flag -> one-hot class and reg field
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module gsu_prefix_decode
  import sreg_dreg_select_controller_pkg::*;
(
  input  logic              [7:0] opcode,
  input  logic                    b_flag,
  output logic       [CLS_W-1:0] cls,
  output logic              [3:0] n
);

  logic [3:0] hi;

  assign hi = opcode[7:4];
  assign n  = opcode[3:0];

  // With B set, TO and FROM encodings become MOVE and MOVES
  always_comb begin
    cls = '0;
    if (hi == OP_WITH)                 cls[CLS_WITH]  = 1'b1;
    else if (hi == OP_TO   && !b_flag) cls[CLS_TO]    = 1'b1;
    else if (hi == OP_FROM && !b_flag) cls[CLS_FROM]  = 1'b1;
    else if (hi == OP_TO)              cls[CLS_MOVE]  = 1'b1;
    else if (hi == OP_FROM)            cls[CLS_MOVES] = 1'b1;
    else                               cls[CLS_OTHER] = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/sreg_dreg_select_controller.sv
// ---------------------------------------------------------------
// sreg_dreg_select_controller : GSU Sreg/Dreg prefix sequencing
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module sreg_dreg_select_controller #(
  parameter logic [3:0] DEFAULT_REG = sreg_dreg_select_controller_pkg::DEFAULT_REG,
  parameter int         MOVE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ins_valid,
  output logic       ins_ready,
  input  logic [7:0] ins_opcode,
  input  logic       ins_done,
  output logic [3:0] ysel,
  output logic [3:0] zsel,
  output logic       b_flag,
  output logic       move_we,
  output logic       moves_flags,
  output logic       busy
);

  import sreg_dreg_select_controller_pkg::*;

  localparam logic [1:0] LAST = 2'(MOVE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [3:0]       sreg, sreg_nxt, dreg, dreg_nxt;
  logic [3:0]       ysel_nxt, zsel_nxt;
  logic             b_nxt, we_nxt, mf_nxt;
  logic             is_moves, is_moves_nxt;
  logic [1:0]       cnt, cnt_nxt;
  logic             accept;
  logic [CLS_W-1:0] cls;
  logic [3:0]       n;

  assign accept = ins_valid && ins_ready;

  gsu_prefix_decode u_decode (
    .opcode (ins_opcode),
    .b_flag (b_flag),
    .cls    (cls),
    .n      (n)
  );

  always_comb begin
    state_nxt    = state;
    sreg_nxt     = sreg;
    dreg_nxt     = dreg;
    ysel_nxt     = ysel;
    zsel_nxt     = zsel;
    b_nxt        = b_flag;
    we_nxt       = 1'b0;
    mf_nxt       = 1'b0;
    is_moves_nxt = is_moves;
    cnt_nxt      = cnt;

    unique case (state)
      ST_IDLE, ST_ARMED: begin
        if (accept) begin
          unique case (1'b1)
            cls[CLS_WITH]: begin
              sreg_nxt  = n;
              dreg_nxt  = n;
              ysel_nxt  = n;
              zsel_nxt  = n;
              b_nxt     = 1'b1;
              state_nxt = ST_ARMED;
            end
            cls[CLS_TO]: begin
              dreg_nxt  = n;
              zsel_nxt  = n;
              state_nxt = ST_ARMED;
            end
            cls[CLS_FROM]: begin
              sreg_nxt  = n;
              ysel_nxt  = n;
              state_nxt = ST_ARMED;
            end
            cls[CLS_MOVE], cls[CLS_MOVES]: begin
              is_moves_nxt = cls[CLS_MOVES];
              ysel_nxt     = cls[CLS_MOVES] ? n : sreg;
              zsel_nxt     = cls[CLS_MOVES] ? dreg : n;
              cnt_nxt      = 2'd0;
              we_nxt       = (LAST == 2'd0);
              mf_nxt       = (LAST == 2'd0) && cls[CLS_MOVES];
              state_nxt    = ST_MOVE;
            end
            default: begin
              ysel_nxt  = sreg;
              zsel_nxt  = dreg;
              state_nxt = ST_BUSY;
            end
          endcase
        end
      end
      ST_BUSY: begin
        if (ins_done) state_nxt = ST_IDLE;
      end
      ST_MOVE: begin
        if (cnt == LAST) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + 2'd1;
          we_nxt  = ((cnt + 2'd1) == LAST);
          mf_nxt  = ((cnt + 2'd1) == LAST) && is_moves;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Leaving BUSY or MOVE drops the whole prefix context
    if ((state == ST_BUSY || state == ST_MOVE) && state_nxt == ST_IDLE) begin
      sreg_nxt = DEFAULT_REG;
      dreg_nxt = DEFAULT_REG;
      ysel_nxt = DEFAULT_REG;
      zsel_nxt = DEFAULT_REG;
      b_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      sreg        <= DEFAULT_REG;
      dreg        <= DEFAULT_REG;
      ysel        <= DEFAULT_REG;
      zsel        <= DEFAULT_REG;
      b_flag      <= 1'b0;
      move_we     <= 1'b0;
      moves_flags <= 1'b0;
      busy        <= 1'b0;
      ins_ready   <= 1'b1;
      is_moves    <= 1'b0;
      cnt         <= 2'd0;
    end else begin
      state       <= state_nxt;
      sreg        <= sreg_nxt;
      dreg        <= dreg_nxt;
      ysel        <= ysel_nxt;
      zsel        <= zsel_nxt;
      b_flag      <= b_nxt;
      move_we     <= we_nxt;
      moves_flags <= mf_nxt;
      busy        <= (state_nxt == ST_BUSY) || (state_nxt == ST_MOVE);
      ins_ready   <= (state_nxt == ST_IDLE) || (state_nxt == ST_ARMED);
      is_moves    <= is_moves_nxt;
      cnt         <= cnt_nxt;
    end
  end

endmodule

`default_nettype wire
